// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates instruction fetch, load and committed store requests onto a
//   single byte engine. Fixed priority is store > load > fetch. The winner's
//   fields are latched and held on the eng_* outputs while the job runs.
//   A speculative flush cancels in-flight fetch/load jobs but never a store.
//
//   Optional feature (macro MEM_ARBITER_STARVE_GUARD_EN):
//     fetch anti-starvation. A 4-bit counter records how many arbitrations in
//     a row fetch has lost. Once it reaches STARVE_LIMIT, a pending fetch
//     beats a load, but never a store. Without the macro the counter does not
//     exist and pure fixed priority applies.
//
//   Parameters
//     STARVE_LIMIT  anti-starvation threshold, 1..15 (default 4)
//
//   Ports
//     clk        clock, rising edge
//     rst        synchronous active-high reset; overrides every other input
//     rdy        when low, every register (outputs included) holds
//     flush      speculative-cancel pulse
//     fet_req/fet_addr                   fetch request, held until granted
//     ld_req/ld_op/ld_addr/ld_id         load request, held until granted
//     st_req/st_op/st_addr/st_val        store request, held until granted
//     fet_gnt/ld_gnt/st_gnt              registered one-cycle grant pulses
//     eng_start  one-cycle pulse launching the engine job
//     eng_kind   0 fetch, 1 load, 2 store
//     eng_op/eng_addr/eng_val/eng_id     latched job fields
//     eng_abort  one-cycle pulse cancelling the in-flight job
//     eng_done   engine completion pulse (ignored while idle)
//     arb_busy   high while a job is in flight
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       fet_req,
  input  logic [`XLEN-1:0]           fet_addr,
  input  logic                       ld_req,
  input  logic [`INST_OP_WIDTH-1:0]  ld_op,
  input  logic [`XLEN-1:0]           ld_addr,
  input  logic [`ROB_SIZE_WIDTH-1:0] ld_id,
  input  logic                       st_req,
  input  logic [`INST_OP_WIDTH-1:0]  st_op,
  input  logic [`XLEN-1:0]           st_addr,
  input  logic [`XLEN-1:0]           st_val,
  output logic                       fet_gnt,
  output logic                       ld_gnt,
  output logic                       st_gnt,
  output logic                       eng_start,
  output logic [1:0]                 eng_kind,
  output logic [`INST_OP_WIDTH-1:0]  eng_op,
  output logic [`XLEN-1:0]           eng_addr,
  output logic [`XLEN-1:0]           eng_val,
  output logic [`ROB_SIZE_WIDTH-1:0] eng_id,
  output logic                       eng_abort,
  input  logic                       eng_done,
  output logic                       arb_busy
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] KIND_FET = 2'd0;
  localparam logic [1:0] KIND_LD  = 2'd1;
  localparam logic [1:0] KIND_ST  = 2'd2;

  state_t state, state_nx;

  logic idle;
  logic fet_boost;
  logic pick_st, pick_ld, pick_fet;

  logic                       fet_gnt_d, ld_gnt_d, st_gnt_d;
  logic                       eng_start_d, eng_abort_d;
  logic [1:0]                 eng_kind_d;
  logic [`INST_OP_WIDTH-1:0]  eng_op_d;
  logic [`XLEN-1:0]           eng_addr_d;
  logic [`XLEN-1:0]           eng_val_d;
  logic [`ROB_SIZE_WIDTH-1:0] eng_id_d;

  // ---------------------------------------------------------------------------
  // Arbitration. Only evaluated in IDLE; the three picks are mutually
  // exclusive. Flush removes load and fetch from contention but not store.
  // ---------------------------------------------------------------------------
  assign idle     = (state == IDLE);
  assign pick_st  = idle && st_req;
  assign pick_fet = idle && !flush && !st_req && fet_req && (fet_boost || !ld_req);
  assign pick_ld  = idle && !flush && !st_req && ld_req && !fet_boost;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign fet_boost = fet_req && (starve_cnt == LIMIT);

  // Counts arbitrations a pending fetch has lost; cleared when fetch wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (rdy) begin
      if (pick_fet) begin
        starve_cnt <= '0;
      end else if (fet_req && (pick_st || pick_ld) && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign fet_boost = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fet_gnt   <= 1'b0;
      ld_gnt    <= 1'b0;
      st_gnt    <= 1'b0;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_kind  <= '0;
      eng_op    <= '0;
      eng_addr  <= '0;
      eng_val   <= '0;
      eng_id    <= '0;
    end else if (rdy) begin
      state     <= state_nx;
      fet_gnt   <= fet_gnt_d;
      ld_gnt    <= ld_gnt_d;
      st_gnt    <= st_gnt_d;
      eng_start <= eng_start_d;
      eng_abort <= eng_abort_d;
      eng_kind  <= eng_kind_d;
      eng_op    <= eng_op_d;
      eng_addr  <= eng_addr_d;
      eng_val   <= eng_val_d;
      eng_id    <= eng_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Completion wins over a coincident flush, and a store
  // job ignores flush entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pick_st || pick_ld || pick_fet) state_nx = BUSY;
      end
      BUSY: begin
        if (eng_done) begin
          state_nx = IDLE;
        end else if (flush && (eng_kind != KIND_ST)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Job fields hold
  // unless a new job is launched.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fet_gnt_d   = 1'b0;
    ld_gnt_d    = 1'b0;
    st_gnt_d    = 1'b0;
    eng_start_d = 1'b0;
    eng_abort_d = 1'b0;
    eng_kind_d  = eng_kind;
    eng_op_d    = eng_op;
    eng_addr_d  = eng_addr;
    eng_val_d   = eng_val;
    eng_id_d    = eng_id;

    if (pick_st) begin
      st_gnt_d    = 1'b1;
      eng_start_d = 1'b1;
      eng_kind_d  = KIND_ST;
      eng_op_d    = st_op;
      eng_addr_d  = st_addr;
      eng_val_d   = st_val;
      eng_id_d    = '0;
    end else if (pick_ld) begin
      ld_gnt_d    = 1'b1;
      eng_start_d = 1'b1;
      eng_kind_d  = KIND_LD;
      eng_op_d    = ld_op;
      eng_addr_d  = ld_addr;
      eng_val_d   = '0;
      eng_id_d    = ld_id;
    end else if (pick_fet) begin
      fet_gnt_d   = 1'b1;
      eng_start_d = 1'b1;
      eng_kind_d  = KIND_FET;
      eng_op_d    = '0;
      eng_addr_d  = fet_addr;
      eng_val_d   = '0;
      eng_id_d    = '0;
    end

    if ((state == BUSY) && flush && !eng_done && (eng_kind != KIND_ST)) begin
      eng_abort_d = 1'b1;
    end
  end

  assign arb_busy = (state == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter (STARVE_LIMIT = 2). A transaction-level
//   reference model predicts every output each cycle; directed scenarios cover
//   priority, starvation, flush/abort, reset and rdy stall, followed by a
//   randomized phase. Honours MEM_ARBITER_STARVE_GUARD_EN like the design.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module tb_mem_arbiter;

  localparam int XL  = `XLEN;
  localparam int OPW = `INST_OP_WIDTH;
  localparam int IDW = `ROB_SIZE_WIDTH;
  localparam int LIM = 2;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef enum int { W_NONE, W_FET, W_LD, W_ST } who_t;

  logic           clk = 1'b0;
  logic           rst, rdy, flush, eng_done;
  logic           fet_req, ld_req, st_req;
  logic [XL-1:0]  fet_addr, ld_addr, st_addr, st_val;
  logic [OPW-1:0] ld_op, st_op;
  logic [IDW-1:0] ld_id;

  logic           fet_gnt, ld_gnt, st_gnt, eng_start, eng_abort, arb_busy;
  logic [1:0]     eng_kind;
  logic [OPW-1:0] eng_op;
  logic [XL-1:0]  eng_addr, eng_val;
  logic [IDW-1:0] eng_id;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fet_req(fet_req), .fet_addr(fet_addr),
    .ld_req(ld_req), .ld_op(ld_op), .ld_addr(ld_addr), .ld_id(ld_id),
    .st_req(st_req), .st_op(st_op), .st_addr(st_addr), .st_val(st_val),
    .fet_gnt(fet_gnt), .ld_gnt(ld_gnt), .st_gnt(st_gnt),
    .eng_start(eng_start), .eng_kind(eng_kind), .eng_op(eng_op),
    .eng_addr(eng_addr), .eng_val(eng_val), .eng_id(eng_id),
    .eng_abort(eng_abort), .eng_done(eng_done), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: one job slot plus the visible pulses and latched fields.
  logic           m_busy, m_fg, m_lg, m_sg, m_start, m_abort;
  logic [1:0]     m_kind;
  logic [OPW-1:0] m_op;
  logic [XL-1:0]  m_addr, m_val;
  logic [IDW-1:0] m_id;
  int             m_starve;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task automatic model_step();
    who_t win;
    if (rst) begin
      {m_busy, m_fg, m_lg, m_sg, m_start, m_abort} = '0;
      m_kind = '0; m_op = '0; m_addr = '0; m_val = '0; m_id = '0;
      m_starve = 0;
    end else if (rdy) begin
      {m_fg, m_lg, m_sg, m_start, m_abort} = '0;
      if (!m_busy) begin
        win = W_NONE;
        if (st_req)                                        win = W_ST;
        else if (!flush && fet_req && GUARD && m_starve == LIM) win = W_FET;
        else if (!flush && ld_req)                         win = W_LD;
        else if (!flush && fet_req)                        win = W_FET;
        if (win == W_FET) m_starve = 0;
        else if (win != W_NONE && fet_req && m_starve < LIM) m_starve++;
        case (win)
          W_ST:  begin m_sg = 1; m_kind = 2; m_op = st_op; m_addr = st_addr; m_val = st_val; m_id = '0; end
          W_LD:  begin m_lg = 1; m_kind = 1; m_op = ld_op; m_addr = ld_addr; m_val = '0; m_id = ld_id; end
          W_FET: begin m_fg = 1; m_kind = 0; m_op = '0; m_addr = fet_addr; m_val = '0; m_id = '0; end
          default: ;
        endcase
        if (win != W_NONE) begin m_start = 1; m_busy = 1; end
      end else if (eng_done) begin
        m_busy = 0;
      end else if (flush && m_kind != 2) begin
        m_abort = 1;
        m_busy  = 0;
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".arb_busy"},  arb_busy,  m_busy);
    check({ctx, ".fet_gnt"},   fet_gnt,   m_fg);
    check({ctx, ".ld_gnt"},    ld_gnt,    m_lg);
    check({ctx, ".st_gnt"},    st_gnt,    m_sg);
    check({ctx, ".eng_start"}, eng_start, m_start);
    check({ctx, ".eng_abort"}, eng_abort, m_abort);
    check({ctx, ".eng_kind"},  eng_kind,  m_kind);
    check({ctx, ".eng_op"},    eng_op,    m_op);
    check({ctx, ".eng_addr"},  eng_addr,  m_addr);
    check({ctx, ".eng_val"},   eng_val,   m_val);
    check({ctx, ".eng_id"},    eng_id,    m_id);
  endtask

  task automatic cycle(input string ctx);
    model_step();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic quiet();
    rst = 0; rdy = 1; flush = 0; eng_done = 0;
    fet_req = 0; ld_req = 0; st_req = 0;
  endtask

  function automatic logic [XL-1:0] rnd_xl();
    return XL'({$urandom, $urandom});
  endfunction

  logic [XL+XL+OPW+IDW+8:0] snap;

  initial begin
    quiet();
    fet_addr = 'h40; ld_addr = 'h80; st_addr = 'hC0; st_val = 'h1234;
    ld_op = 'h3; st_op = 'h5; ld_id = 'h2;

    // Reset state
    rst = 1;
    cycle("reset0");
    cycle("reset1");
    check("reset.busy_low", arb_busy, 1'b0);
    rst = 0;
    cycle("idle");

    // Simultaneous requests: store, then load, then fetch
    fet_req = 1; ld_req = 1; st_req = 1;
    cycle("prio.st");
    check("prio.st_gnt", st_gnt, 1'b1);
    check("prio.st_kind", eng_kind, 2'd2);
    st_req = 0; eng_done = 1;
    cycle("prio.done1");
    eng_done = 0;
    cycle("prio.ld");
    check("prio.ld_gnt", ld_gnt, 1'b1);
    ld_req = 0; eng_done = 1;
    cycle("prio.done2");
    eng_done = 0;
    cycle("prio.fet");
    check("prio.fet_gnt", fet_gnt, 1'b1);
    check("prio.fet_fields", {eng_op, eng_val, eng_id}, '0);
    fet_req = 0; eng_done = 1;
    cycle("prio.done3");
    eng_done = 0;

    // Starvation: fetch held against a continuously asserted load
    rst = 1; cycle("starve.rst"); rst = 0;
    fet_req = 1; ld_req = 1; ld_addr = 'h90;
    for (int a = 1; a <= 3; a++) begin
      cycle("starve.arb");
      if (a < 3) begin
        eng_done = 1; cycle("starve.done"); eng_done = 0;
      end
    end
    check("starve.third_fet", fet_gnt, GUARD);
    check("starve.third_ld", ld_gnt, !GUARD);
    fet_req = 0; ld_req = 0; eng_done = 1;
    cycle("starve.end");
    eng_done = 0;

    // eng_done while idle is ignored
    eng_done = 1;
    cycle("idle_done");
    check("idle_done.busy", arb_busy, 1'b0);
    eng_done = 0;

    // Flush in idle blocks load, store still proceeds
    flush = 1; ld_req = 1;
    cycle("iflush.ld");
    check("iflush.no_ld_gnt", ld_gnt, 1'b0);
    st_req = 1; st_addr = 'h44;
    cycle("iflush.st");
    check("iflush.st_gnt", st_gnt, 1'b1);
    flush = 0; st_req = 0; eng_done = 1;
    cycle("iflush.done");
    eng_done = 0; ld_req = 0;
    cycle("iflush.idle");

    // Flush while a load is busy aborts it
    ld_req = 1; ld_addr = 'h100; ld_id = 'h5;
    cycle("abort.grant");
    check("abort.ld_addr", eng_addr, 'h100);
    ld_req = 0; flush = 1;
    cycle("abort.flush");
    check("abort.pulse", eng_abort, 1'b1);
    check("abort.not_busy", arb_busy, 1'b0);
    flush = 0;
    cycle("abort.after");
    check("abort.no_regrant", ld_gnt, 1'b0);

    // Flush during a store is ignored
    st_req = 1; st_addr = 'h20; st_val = 'hDEADBEEF; st_op = 'h7;
    cycle("stflush.grant");
    st_req = 0; flush = 1;
    cycle("stflush.flush");
    check("stflush.no_abort", eng_abort, 1'b0);
    check("stflush.addr", eng_addr, 'h20);
    check("stflush.val", eng_val, XL'(32'hDEADBEEF));
    flush = 0;
    cycle("stflush.hold");
    eng_done = 1;
    cycle("stflush.done");
    check("stflush.idle", arb_busy, 1'b0);
    eng_done = 0;

    // Coincident flush and done complete normally
    ld_req = 1;
    cycle("coinc.grant");
    ld_req = 0; flush = 1; eng_done = 1;
    cycle("coinc.edge");
    check("coinc.no_abort", eng_abort, 1'b0);
    flush = 0; eng_done = 0;

    // Reset while busy drops the job, no abort
    fet_req = 1; fet_addr = 'h400;
    cycle("rstbusy.grant");
    fet_req = 0; rst = 1; flush = 1;
    cycle("rstbusy.rst");
    check("rstbusy.outs", {arb_busy, fet_gnt, eng_start, eng_abort, eng_addr}, '0);
    rst = 0; flush = 0;

    // rdy low for three cycles holds every output
    st_req = 1; st_addr = 'h88;
    cycle("stall.grant");
    st_req = 0;
    snap = {arb_busy, fet_gnt, ld_gnt, st_gnt, eng_start, eng_abort, eng_kind, eng_op, eng_addr, eng_val, eng_id};
    rdy = 0; eng_done = 1; flush = 1; ld_req = 1;
    for (int k = 0; k < 3; k++) begin
      cycle("stall.hold");
      check("stall.snapshot",
            {arb_busy, fet_gnt, ld_gnt, st_gnt, eng_start, eng_abort, eng_kind, eng_op, eng_addr, eng_val, eng_id},
            snap);
    end
    rdy = 1; flush = 0; ld_req = 0;
    cycle("stall.resume");
    eng_done = 0;
    cycle("stall.idle");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      eng_done = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      if (fet_req ? m_fg : ($urandom_range(0, 2) == 0)) begin
        fet_req = $urandom_range(0, 2) == 0; fet_addr = rnd_xl();
      end
      if (ld_req ? m_lg : ($urandom_range(0, 2) == 0)) begin
        ld_req = $urandom_range(0, 2) == 0; ld_addr = rnd_xl();
        ld_op = OPW'($urandom); ld_id = IDW'($urandom);
      end
      if (st_req ? m_sg : ($urandom_range(0, 3) == 0)) begin
        st_req = $urandom_range(0, 2) == 0; st_addr = rnd_xl(); st_val = rnd_xl();
        st_op = OPW'($urandom);
      end
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
